// File: rtl/lfsr_stream_checker.sv
// Measures each full period of an upstream LFSR bit stream: length, ones/zeroes and longest runs.
// Build option: define LFSR_PERIOD_CHECK_EN to compare each period length against 2^LFSR_WIDTH-1.
//
// state   | meaning
// ST_SYNC | waiting for the first period marker; incoming bits are discarded
// ST_MEAS | accumulating the current period; a marker closes it and reports results
module lfsr_stream_checker #(
  parameter int LFSR_WIDTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             bit_in,
  input  logic             tick_in,
  output logic [CNT_W-1:0] period_len,
  output logic [CNT_W-1:0] ones_cnt,
  output logic [CNT_W-1:0] zeroes_cnt,
  output logic [CNT_W-1:0] max_run_ones,
  output logic [CNT_W-1:0] max_run_zeroes,
  output logic             done,
  output logic             synced,
  output logic             err_balance,
  output logic             err_period,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {ST_SYNC, ST_MEAS} state_t;

  state_t state_q, state_nx;
  logic   start, close, meas;

  logic [CNT_W-1:0] len_q, ones_q, zeroes_q, run_q, max1_q, max0_q;
  logic [CNT_W-1:0] len_n, ones_n, zeroes_n, run_n, max1_n, max0_n;
  logic             prev_q;
  logic             first, same, ovf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_SYNC;
    else        state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    start    = 1'b0;
    close    = 1'b0;
    meas     = 1'b0;
    case (state_q)
      ST_SYNC: begin
        if (en && tick_in) begin
          state_nx = ST_MEAS;
          start    = 1'b1;
        end
      end
      ST_MEAS: begin
        meas  = en;
        close = en && tick_in;
      end
      default: state_nx = ST_SYNC;
    endcase
  end

  // The max registers always include the open run, so closing a run needs no extra step.
  always_comb begin
    first    = (len_q == '0);
    same     = !first && (bit_in == prev_q);
    len_n    = (len_q == CNT_MAX) ? len_q : len_q + CNT_ONE;
    ones_n   = ones_q;
    zeroes_n = zeroes_q;
    if (bit_in) ones_n   = (ones_q == CNT_MAX) ? ones_q : ones_q + CNT_ONE;
    else        zeroes_n = (zeroes_q == CNT_MAX) ? zeroes_q : zeroes_q + CNT_ONE;
    run_n    = CNT_ONE;
    if (same) run_n = (run_q == CNT_MAX) ? run_q : run_q + CNT_ONE;
    max1_n   = (bit_in && run_n > max1_q) ? run_n : max1_q;
    max0_n   = (!bit_in && run_n > max0_q) ? run_n : max0_q;
    ovf      = meas && ((len_q == CNT_MAX) ||
                        (bit_in && ones_q == CNT_MAX) ||
                        (!bit_in && zeroes_q == CNT_MAX) ||
                        (same && run_q == CNT_MAX));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q    <= '0;
      ones_q   <= '0;
      zeroes_q <= '0;
      run_q    <= '0;
      max1_q   <= '0;
      max0_q   <= '0;
      prev_q   <= 1'b0;
    end else if (start || close) begin
      len_q    <= '0;
      ones_q   <= '0;
      zeroes_q <= '0;
      run_q    <= '0;
      max1_q   <= '0;
      max0_q   <= '0;
      prev_q   <= 1'b0;
    end else if (meas) begin
      len_q    <= len_n;
      ones_q   <= ones_n;
      zeroes_q <= zeroes_n;
      run_q    <= run_n;
      max1_q   <= max1_n;
      max0_q   <= max0_n;
      prev_q   <= bit_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_len     <= '0;
      ones_cnt       <= '0;
      zeroes_cnt     <= '0;
      max_run_ones   <= '0;
      max_run_zeroes <= '0;
      done           <= 1'b0;
      synced         <= 1'b0;
      err_balance    <= 1'b0;
      sat            <= 1'b0;
    end else begin
      done   <= close;
      synced <= synced | start;
      sat    <= sat | ovf;
      if (close) begin
        period_len     <= len_n;
        ones_cnt       <= ones_n;
        zeroes_cnt     <= zeroes_n;
        max_run_ones   <= max1_n;
        max_run_zeroes <= max0_n;
        // One extra bit so a saturated zero count cannot wrap the comparison.
        err_balance    <= ({1'b0, ones_n} != ({1'b0, zeroes_n} + {1'b0, CNT_ONE}));
      end
    end
  end

`ifdef LFSR_PERIOD_CHECK_EN
  localparam logic [CNT_W-1:0] PERIOD = CNT_W'((2 ** LFSR_WIDTH) - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     err_period <= 1'b0;
    else if (close) err_period <= (len_n != PERIOD);
  end
`else
  assign err_period = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Randomized bench for lfsr_stream_checker: two instances (wide and narrow counters) against a queue-based model.
module tb_lfsr_stream_checker;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0, bit_in = 1'b0, tick_in = 1'b0;

  logic [15:0] w_len, w_ones, w_zeroes, w_max1, w_max0;
  logic        w_done, w_synced, w_errb, w_errp, w_sat;
  logic [3:0]  s_len, s_ones, s_zeroes, s_max1, s_max0;
  logic        s_done, s_synced, s_errb, s_errp, s_sat;

  always #5 clk = ~clk;

  lfsr_stream_checker #(.LFSR_WIDTH(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .en(en), .bit_in(bit_in), .tick_in(tick_in),
    .period_len(w_len), .ones_cnt(w_ones), .zeroes_cnt(w_zeroes),
    .max_run_ones(w_max1), .max_run_zeroes(w_max0), .done(w_done), .synced(w_synced),
    .err_balance(w_errb), .err_period(w_errp), .sat(w_sat));

  lfsr_stream_checker #(.LFSR_WIDTH(4), .CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .en(en), .bit_in(bit_in), .tick_in(tick_in),
    .period_len(s_len), .ones_cnt(s_ones), .zeroes_cnt(s_zeroes),
    .max_run_ones(s_max1), .max_run_zeroes(s_max0), .done(s_done), .synced(s_synced),
    .err_balance(s_errb), .err_period(s_errp), .sat(s_sat));

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: bits of the open period, plus expected registered outputs per instance.
  bit q[$];
  bit m_synced;
  int cap[2] = '{65535, 15};
  int e_len[2], e_ones[2], e_zeroes[2], e_max1[2], e_max0[2];
  bit e_errb[2], e_errp[2], e_sat[2], e_done, e_synced;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic int cap_to(input int v, input int c);
    return (v > c) ? c : v;
  endfunction

  // Statistics of the queued period with counters limited to c; ovf if any true count exceeds c.
  task automatic stats(input int c, output int len, output int ones, output int zer,
                       output int mx1, output int mx0, output bit ovf);
    int run;
    int n1, n0;
    n1 = 0; n0 = 0; mx1 = 0; mx0 = 0; run = 0; ovf = 0;
    for (int i = 0; i < q.size(); i++) begin
      if (i > 0 && q[i] == q[i-1]) run++;
      else run = 1;
      if (q[i]) begin n1++; mx1 = (cap_to(run, c) > mx1) ? cap_to(run, c) : mx1; end
      else      begin n0++; mx0 = (cap_to(run, c) > mx0) ? cap_to(run, c) : mx0; end
      if (run > c) ovf = 1;
    end
    if (q.size() > c || n1 > c || n0 > c) ovf = 1;
    len = cap_to(q.size(), c); ones = cap_to(n1, c); zer = cap_to(n0, c);
  endtask

  task automatic model_reset();
    q.delete();
    m_synced = 0; e_done = 0; e_synced = 0;
    for (int k = 0; k < 2; k++) begin
      e_len[k] = 0; e_ones[k] = 0; e_zeroes[k] = 0; e_max1[k] = 0; e_max0[k] = 0;
      e_errb[k] = 0; e_errp[k] = 0; e_sat[k] = 0;
    end
  endtask

  task automatic model_edge(input bit e, input bit b, input bit t);
    int len, ones, zer, mx1, mx0;
    bit ovf;
    e_done = 0;
    if (!reset || !e) return;
    if (!m_synced) begin
      if (t) begin m_synced = 1; q.delete(); end
    end else begin
      q.push_back(b);
      for (int k = 0; k < 2; k++) begin
        stats(cap[k], len, ones, zer, mx1, mx0, ovf);
        if (ovf) e_sat[k] = 1;
        if (t) begin
          e_len[k] = len; e_ones[k] = ones; e_zeroes[k] = zer;
          e_max1[k] = mx1; e_max0[k] = mx0;
          e_errb[k] = (ones != zer + 1);
`ifdef LFSR_PERIOD_CHECK_EN
          e_errp[k] = (len != 15);
`else
          e_errp[k] = 0;
`endif
        end
      end
      if (t) begin e_done = 1; q.delete(); end
    end
    e_synced = m_synced;
  endtask

  task automatic compare_all();
    check("w.done", w_done, e_done);       check("s.done", s_done, e_done);
    check("w.synced", w_synced, e_synced); check("s.synced", s_synced, e_synced);
    check("w.len", w_len, e_len[0]);       check("s.len", s_len, e_len[1]);
    check("w.ones", w_ones, e_ones[0]);    check("s.ones", s_ones, e_ones[1]);
    check("w.zeroes", w_zeroes, e_zeroes[0]); check("s.zeroes", s_zeroes, e_zeroes[1]);
    check("w.max1", w_max1, e_max1[0]);    check("s.max1", s_max1, e_max1[1]);
    check("w.max0", w_max0, e_max0[0]);    check("s.max0", s_max0, e_max0[1]);
    check("w.errb", w_errb, e_errb[0]);    check("s.errb", s_errb, e_errb[1]);
    check("w.errp", w_errp, e_errp[0]);    check("s.errp", s_errp, e_errp[1]);
    check("w.sat", w_sat, e_sat[0]);       check("s.sat", s_sat, e_sat[1]);
  endtask

  task automatic step(input bit e, input bit b, input bit t);
    en = e; bit_in = b; tick_in = t;
    @(posedge clk);
    model_edge(e, b, t);
    #1;
    compare_all();
  endtask

  // Sends a period of n bits taken MSB-first from pat; optionally inserts en=0 cycles after bit gap_at.
  task automatic send_period(input logic [31:0] pat, input int n, input int gap_at, input int gap_len);
    for (int i = 0; i < n; i++) begin
      step(1'b1, pat[n-1-i], (i == n - 1));
      if (i == gap_at)
        for (int g = 0; g < gap_len; g++) step(1'b0, 1'($urandom), 1'($urandom));
    end
  endtask

  localparam logic [31:0] GOOD = 32'b000100110101111;
  localparam logic [31:0] BAD  = 32'b000100110100111;

  initial begin
    model_reset();
    // Reset held for 400 ns with random stimulus present.
    for (int i = 0; i < 40; i++) step(1'($urandom), 1'($urandom), 1'($urandom));
    #2 reset = 1'b1;
    step(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom), 1'b0);
    step(1'b1, 1'b0, 1'b1);                 // first tick
    send_period(GOOD, 15, -1, 0);
    step(1'b1, 1'b0, 1'b0);
    check("good.done_single", w_done, 1'b0);
    q.delete(); // the extra bit above opened a period; restart cleanly via reset-free resync not needed
    // Re-align: the extra bit belongs to the model queue too, so rebuild both sides with a reset.
    #2 reset = 1'b0; #1 model_reset(); compare_all();
    step(1'b1, 1'b1, 1'b1);
    #2 reset = 1'b1;
    step(1'b1, 1'b0, 1'b1);                 // tick in SYNC
    send_period(GOOD, 15, 6, 3);            // en gap mid-stream
    send_period(BAD, 15, -1, 0);            // flipped bit -> balance error
    send_period(GOOD >> 1, 14, -1, 0);      // short period
    step(1'b1, 1'b1, 1'b1);                 // back-to-back tick: length-1 period
    step(1'b1, 1'b0, 1'b1);

    // Reset in the middle of a period (after bit 7).
    for (int i = 0; i < 7; i++) step(1'b1, GOOD[14-i], 1'b0);
    #2 reset = 1'b0;
    #1 model_reset();
    compare_all();
    step(1'b1, 1'b1, 1'b1);
    #2 reset = 1'b1;
    step(1'b1, 1'b1, 1'b0);                 // still in SYNC: discarded
    step(1'b1, 1'b0, 1'b1);
    send_period(GOOD, 15, -1, 0);

    // Random periods, including lengths that saturate the narrow instance.
    for (int p = 0; p < 30; p++) begin
      int n;
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) step(1'b0, 1'($urandom), 1'($urandom));
        step(1'b1, ($urandom_range(0, 4) != 0) ? bit_in : 1'(~bit_in), (i == n - 1));
      end
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
